// File: rtl/xadc_drp_scheduler_if.sv
// Signal bundle between the XADC DRP scheduler and its surroundings:
// the XADC DRP port, the host register port and the scanned channel results.
interface xadc_drp_scheduler_if;
  logic        eoc;
  logic        drdy;
  logic [15:0] drp_do;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_err;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        busy;

  modport slave (
    input  eoc, drdy, drp_do, host_req, host_we, host_addr, host_wdata,
    output den, dwe, daddr, di, host_ack, host_rdata, host_err, ch_data, ch_valid, busy
  );

  modport master (
    output eoc, drdy, drp_do, host_req, host_we, host_addr, host_wdata,
    input  den, dwe, daddr, di, host_ack, host_rdata, host_err, ch_data, ch_valid, busy
  );
endinterface

// File: rtl/xadc_drp_scheduler.sv
// Arbitrates the XADC DRP port between an eoc-driven round-robin scan of four
// aux channels and a host register port; keeps the top byte of each scan result.
module xadc_drp_scheduler #(
  parameter logic [6:0] CH0_ADDR = 7'h1E,
  parameter logic [6:0] CH1_ADDR = 7'h17,
  parameter logic [6:0] CH2_ADDR = 7'h1F,
  parameter logic [6:0] CH3_ADDR = 7'h16,
  parameter int         TIMEOUT  = 64
) (
  input logic                  clk,
  input logic                  resetn,
  xadc_drp_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_SCAN, OWN_HOST} owner_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  owner_t           r_owner;
  owner_t           r_last_owner;
  logic [1:0]       r_slot;
  logic             r_scan_pend;
  logic [CNT_W-1:0] r_tcnt;
  logic             r_den;
  logic             r_dwe;
  logic [6:0]       r_daddr;
  logic [15:0]      r_di;
  logic             r_host_ack;
  logic [15:0]      r_host_rdata;
  logic             r_host_err;
  logic [31:0]      r_ch_data;
  logic [3:0]       r_ch_valid;
  logic             r_busy;

  logic             w_host_pend;
  logic             w_grant_host;
  logic             w_timeout;
  logic [6:0]       w_slot_addr;

  // A request is not re-seen in the cycle its ack is out, so a host that
  // drops host_req on ack never gets a duplicate transaction.
  assign w_host_pend  = bus.host_req && !r_host_ack;
  assign w_grant_host = w_host_pend && (!r_scan_pend || r_last_owner == OWN_SCAN);
  assign w_timeout    = (r_tcnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_slot_addr = CH0_ADDR;
    case (r_slot)
      2'd0: w_slot_addr = CH0_ADDR;
      2'd1: w_slot_addr = CH1_ADDR;
      2'd2: w_slot_addr = CH2_ADDR;
      2'd3: w_slot_addr = CH3_ADDR;
      default: w_slot_addr = CH0_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_SCAN;
      r_last_owner <= OWN_SCAN;
      r_slot       <= 2'd0;
      r_scan_pend  <= 1'b0;
      r_tcnt       <= '0;
      r_den        <= 1'b0;
      r_dwe        <= 1'b0;
      r_daddr      <= 7'd0;
      r_di         <= 16'd0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= 16'd0;
      r_host_err   <= 1'b0;
      r_ch_data    <= 32'd0;
      r_ch_valid   <= 4'd0;
      r_busy       <= 1'b0;
    end else begin
      r_den      <= 1'b0;
      r_host_ack <= 1'b0;
      if (bus.eoc) r_scan_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_host_pend || r_scan_pend) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_den   <= 1'b1;
            if (w_grant_host) begin
              r_owner <= OWN_HOST;
              r_daddr <= bus.host_addr;
              r_dwe   <= bus.host_we;
              r_di    <= bus.host_wdata;
            end else begin
              r_owner <= OWN_SCAN;
              r_daddr <= w_slot_addr;
              r_dwe   <= 1'b0;
              r_di    <= 16'd0;
              // An eoc landing on the issue cycle keeps the next scan pending.
              if (!bus.eoc) r_scan_pend <= 1'b0;
            end
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
          r_tcnt  <= '0;
        end

        S_WAIT: begin
          r_tcnt <= r_tcnt + CNT_W'(1);
          if (bus.drdy) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
            if (r_owner == OWN_HOST) begin
              r_host_ack   <= 1'b1;
              r_host_err   <= 1'b0;
              r_host_rdata <= r_dwe ? 16'd0 : bus.drp_do;
            end else begin
              r_ch_data[{r_slot, 3'b000} +: 8] <= bus.drp_do[15:8];
              r_ch_valid[r_slot]               <= 1'b1;
              r_slot                           <= r_slot + 2'd1;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_owner == OWN_HOST) begin
              r_host_ack   <= 1'b1;
              r_host_err   <= 1'b1;
              r_host_rdata <= 16'd0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.den        = r_den;
  assign bus.dwe        = r_dwe;
  assign bus.daddr      = r_daddr;
  assign bus.di         = r_di;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_err   = r_host_err;
  assign bus.ch_data    = r_ch_data;
  assign bus.ch_valid   = r_ch_valid;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: a behavioural DRP responder, vector tables for
// scan and host transactions, hand-written corner sequences and a random phase.
module tb_xadc_drp_scheduler;
  localparam int TIMEOUT = 64;

  logic clk;
  logic resetn;
  xadc_drp_scheduler_if bus();

  xadc_drp_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          drp_lat;
  logic        rsp_drdy;
  logic        man_drdy;
  logic [15:0] rsp_do;
  logic [15:0] man_do;
  logic [15:0] drp_mem [128];
  logic [15:0] ref_mem [128];
  logic [6:0]  den_q [$];
  logic [6:0]  ch_addr [4];

  assign bus.drdy   = rsp_drdy | man_drdy;
  assign bus.drp_do = man_drdy ? man_do : rsp_do;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DRP model: answers drp_lat cycles after den (never when drp_lat is 0);
  // writes land in memory when issued, and write replies carry junk data.
  initial begin
    rsp_drdy = 1'b0;
    rsp_do   = 16'h0000;
    forever begin
      @(negedge clk);
      rsp_drdy = 1'b0;
      if (bus.den) begin
        den_q.push_back(bus.daddr);
        if (bus.dwe) drp_mem[bus.daddr] = bus.di;
        if (drp_lat > 0) begin
          repeat (drp_lat) @(negedge clk);
          rsp_drdy = 1'b1;
          rsp_do   = bus.dwe ? 16'hDEAD : drp_mem[bus.daddr];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " den/dwe/ack/err/busy"},
        64'({bus.den, bus.dwe, bus.host_ack, bus.host_err, bus.busy}), 64'd0);
    chk({tag, " daddr/di"}, 64'({bus.daddr, bus.di}), 64'd0);
    chk({tag, " host_rdata"}, 64'(bus.host_rdata), 64'd0);
    chk({tag, " ch_data"}, 64'(bus.ch_data), 64'd0);
    chk({tag, " ch_valid"}, 64'(bus.ch_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn         = 1'b0;
    bus.eoc        = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 7'd0;
    bus.host_wdata = 16'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.host_ack && n < 300);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 300);
  endtask

  task automatic scan_op(output logic [6:0] a, output logic den_ok, output logic idle_ok);
    int n;
    @(negedge clk); bus.eoc = 1'b1;
    @(negedge clk); bus.eoc = 1'b0;
    n = 0;
    while (!bus.den && n < 20) begin @(negedge clk); n++; end
    den_ok = (n < 20);
    a = bus.daddr;
    wait_idle(n);
    idle_ok = (n < 300);
  endtask

  task automatic host_xact(input logic we, input logic [6:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output logic err, output int den_n,
                           output int ack_n, output logic [6:0] s_addr, output logic s_dwe,
                           output logic [15:0] s_di, output logic ack_gone);
    @(negedge clk);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    den_n = 0;
    do begin @(negedge clk); den_n++; end while (!bus.den && den_n < 20);
    s_addr = bus.daddr;
    s_dwe  = bus.dwe;
    s_di   = bus.di;
    wait_ack(ack_n);
    rd  = bus.host_rdata;
    err = bus.host_err;
    bus.host_req = 1'b0;
    @(negedge clk);
    ack_gone = !bus.host_ack;
  endtask

  typedef struct {
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_valid;
  } scan_vec_t;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } host_vec_t;

  scan_vec_t sv [5];
  host_vec_t hv [6];

  initial begin
    logic [6:0]  a;
    logic        dok, iok, err, dwe_s, gone, we;
    logic [15:0] rd, di_s, wd, exp_rd;
    logic [6:0]  addr_s, addr;
    int          den_n, ack_n, n, lat, op, m_slot;
    logic [7:0]  m_ch [4];
    logic [3:0]  m_valid;

    ch_addr = '{7'h1E, 7'h17, 7'h1F, 7'h16};
    sv = '{'{7'h1E, 32'h000000A5, 4'h1},
           '{7'h17, 32'h00003CA5, 4'h3},
           '{7'h1F, 32'h00FF3CA5, 4'h7},
           '{7'h16, 32'h00FF3CA5, 4'hF},
           '{7'h1E, 32'h00FF3CA5, 4'hF}};
    hv = '{'{1'b0, 7'h41, 16'h0000, 3, 16'h1234, 1'b0},
           '{1'b1, 7'h40, 16'h9000, 2, 16'h0000, 1'b0},
           '{1'b0, 7'h40, 16'h0000, 1, 16'h9000, 1'b0},
           '{1'b0, 7'h7F, 16'h0000, 5, 16'hBEEF, 1'b0},
           '{1'b0, 7'h41, 16'h0000, 0, 16'h0000, 1'b1},
           '{1'b1, 7'h12, 16'h5555, 0, 16'h0000, 1'b1}};

    for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0000;
    drp_mem[7'h1E] = 16'hA511;
    drp_mem[7'h17] = 16'h3C22;
    drp_mem[7'h1F] = 16'hFF33;
    drp_mem[7'h16] = 16'h0044;
    drp_mem[7'h41] = 16'h1234;
    drp_mem[7'h7F] = 16'hBEEF;
    man_drdy = 1'b0;
    man_do   = 16'h0000;
    drp_lat  = 2;

    do_reset();
    check_zero("reset");

    // Round-robin scan of the four slots, then wrap back to slot 0.
    for (int i = 0; i < 5; i++) begin
      scan_op(a, dok, iok);
      chk($sformatf("scan%0d den seen", i), 64'(dok), 64'd1);
      chk($sformatf("scan%0d done", i), 64'(iok), 64'd1);
      chk($sformatf("scan%0d daddr", i), 64'(a), 64'(sv[i].exp_addr));
      chk($sformatf("scan%0d ch_data", i), 64'(bus.ch_data), 64'(sv[i].exp_data));
      chk($sformatf("scan%0d ch_valid", i), 64'(bus.ch_valid), 64'(sv[i].exp_valid));
    end

    // Scan timeout on slot 1 leaves slot and results untouched.
    drp_lat = 0;
    scan_op(a, dok, iok);
    chk("scan timeout daddr", 64'(a), 64'h17);
    chk("scan timeout ch_data", 64'(bus.ch_data), 64'h00FF3CA5);
    chk("scan timeout ch_valid", 64'(bus.ch_valid), 64'hF);
    drp_lat = 2;
    drp_mem[7'h17] = 16'h7E00;
    scan_op(a, dok, iok);
    chk("scan after timeout daddr", 64'(a), 64'h17);
    chk("scan after timeout ch_data", 64'(bus.ch_data), 64'h00FF7EA5);

    // Host transactions, including timeouts.
    for (int i = 0; i < 6; i++) begin
      drp_lat = hv[i].lat;
      host_xact(hv[i].we, hv[i].addr, hv[i].wdata, rd, err, den_n, ack_n,
                addr_s, dwe_s, di_s, gone);
      chk($sformatf("host%0d den latency", i), 64'(den_n), 64'd1);
      chk($sformatf("host%0d daddr", i), 64'(addr_s), 64'(hv[i].addr));
      chk($sformatf("host%0d dwe", i), 64'(dwe_s), 64'(hv[i].we));
      chk($sformatf("host%0d di", i), 64'(di_s), hv[i].we ? 64'(hv[i].wdata) : 64'd0);
      chk($sformatf("host%0d ack latency", i), 64'(ack_n),
          (hv[i].lat > 0) ? 64'(hv[i].lat + 1) : 64'(TIMEOUT + 1));
      chk($sformatf("host%0d rdata", i), 64'(rd), 64'(hv[i].exp_rdata));
      chk($sformatf("host%0d err", i), 64'(err), 64'(hv[i].exp_err));
      chk($sformatf("host%0d ack one cycle", i), 64'(gone), 64'd1);
    end

    // Host and scan pending together: host first (last owner = scan), then alternate.
    do_reset();
    drp_lat = 2;
    den_q.delete();
    @(negedge clk); bus.eoc = 1'b1;
    @(negedge clk);
    bus.eoc       = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 7'h41;
    wait_ack(n);
    chk("arb ack1 seen", 64'(n < 300), 64'd1);
    chk("arb ack1 rdata", 64'(bus.host_rdata), 64'h1234);
    wait_ack(n);
    chk("arb ack2 seen", 64'(n < 300), 64'd1);
    bus.host_req = 1'b0;
    wait_idle(n);
    chk("arb grant count", 64'(den_q.size()), 64'd3);
    if (den_q.size() == 3) begin
      chk("arb grant0", 64'(den_q[0]), 64'h41);
      chk("arb grant1", 64'(den_q[1]), 64'h1E);
      chk("arb grant2", 64'(den_q[2]), 64'h41);
    end

    // Reset while a scan sits in WAIT; a late drdy must be ignored.
    do_reset();
    drp_lat = 0;
    @(negedge clk); bus.eoc = 1'b1;
    @(negedge clk); bus.eoc = 1'b0;
    n = 0;
    while (!bus.den && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("busy in wait", 64'(bus.busy), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_zero("reset in wait");
    resetn   = 1'b1;
    man_drdy = 1'b1;
    man_do   = 16'hC3C3;
    @(negedge clk);
    man_drdy = 1'b0;
    @(negedge clk);
    check_zero("late drdy");

    // Random serialized traffic against a memory-level reference model.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      drp_mem[i] = 16'($urandom);
      ref_mem[i] = drp_mem[i];
    end
    m_slot  = 0;
    m_ch    = '{8'd0, 8'd0, 8'd0, 8'd0};
    m_valid = 4'd0;
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 2));
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      drp_lat = lat;
      if (op == 0) begin
        scan_op(a, dok, iok);
        chk($sformatf("rnd%0d scan daddr", i), 64'(a), 64'(ch_addr[m_slot]));
        if (lat > 0) begin
          m_ch[m_slot]    = ref_mem[ch_addr[m_slot]][15:8];
          m_valid[m_slot] = 1'b1;
          m_slot          = (m_slot + 1) % 4;
        end
        chk($sformatf("rnd%0d ch_data", i), 64'(bus.ch_data),
            64'({m_ch[3], m_ch[2], m_ch[1], m_ch[0]}));
        chk($sformatf("rnd%0d ch_valid", i), 64'(bus.ch_valid), 64'(m_valid));
      end else begin
        we   = (op == 2);
        addr = 7'($urandom_range(0, 127));
        wd   = 16'($urandom);
        host_xact(we, addr, wd, rd, err, den_n, ack_n, addr_s, dwe_s, di_s, gone);
        exp_rd = (lat == 0 || we) ? 16'd0 : ref_mem[addr];
        if (we) ref_mem[addr] = wd;
        chk($sformatf("rnd%0d host daddr", i), 64'(addr_s), 64'(addr));
        chk($sformatf("rnd%0d host ack latency", i), 64'(ack_n),
            (lat > 0) ? 64'(lat + 1) : 64'(TIMEOUT + 1));
        chk($sformatf("rnd%0d host rdata", i), 64'(rd), 64'(exp_rd));
        chk($sformatf("rnd%0d host err", i), 64'(err), 64'(lat == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
